// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : 32-step bit-serial MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_STEP = 6'd31;

    state_t      r_state;
    state_t      w_next;
    logic        r_is_div;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [5:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [63:0] r_work;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;
    logic        w_q_bit;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CALC;
            S_CALC:  if (r_cnt == c_LAST_STEP) w_next = S_SIGN;
            S_SIGN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    assign w_signed = ~op[0];
    assign w_abs_a  = (w_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign w_abs_b  = (w_signed & src_b[31]) ? (32'd0 - src_b) : src_b;

    // Multiply: add into the upper half, then shift the whole pair right.
    assign w_mul_sum = {1'b0, r_work[63:32]} + (r_b[0] ? {1'b0, r_a} : 33'd0);

    // Divide: remainder is always below the divisor, so bit 32 of the
    // 33-bit trial difference is exactly the borrow.
    assign w_rem_sh = {r_work[63:32], r_a[31]};
    assign w_trial  = w_rem_sh - {1'b0, r_b};
    assign w_q_bit  = ~w_trial[32];

    assign w_prod = r_neg_q ? (64'd0 - r_work) : r_work;
    assign w_quot = r_neg_q ? (32'd0 - r_work[31:0]) : r_work[31:0];
    // With a zero divisor the remainder ends up as |a|, so the normal
    // remainder sign fix already reproduces the raw dividend for HI.
    assign w_rem  = r_neg_r ? (32'd0 - r_work[63:32]) : r_work[63:32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= 6'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_work   <= 64'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (r_state == S_SIGN) && !flush;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start && !flush) begin
                        r_is_div <= op[1];
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_neg_q  <= w_signed & (src_a[31] ^ src_b[31]);
                        r_neg_r  <= w_signed & src_a[31];
                        r_dz     <= (src_b == 32'd0);
                        r_cnt    <= 6'd0;
                        r_work   <= 64'd0;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 6'd1;
                    if (r_is_div) begin
                        r_work <= {(w_q_bit ? w_trial[31:0] : w_rem_sh[31:0]),
                                   r_work[30:0], w_q_bit};
                        r_a    <= {r_a[30:0], 1'b0};
                    end else begin
                        r_work <= {w_mul_sum, r_work[31:1]};
                        r_b    <= {1'b0, r_b[31:1]};
                    end
                end
                S_SIGN: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            r_lo <= r_dz ? 32'hFFFF_FFFF : w_quot;
                            r_hi <= w_rem;
                        end else begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Scoreboard bench for muldiv_unit (results, timing, flush, reset).
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb_q[$];

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Reference result as {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        int          sa;
        int          sd;
        case (o)
            2'b00: begin
                ea = {{32{a[31]}}, a};
                eb = {{32{b[31]}}, b};
                return ea * eb;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b11) return {a % b, a / b};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a;
                sd = b;
                return {32'(sa % sd), 32'(sa / sd)};
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) check("unexpected_done", {63'd0, done}, 64'd0);
            else                  check("hilo", {hi, lo}, sb_q.pop_front());
        end
    end

    // Issue one operation from a negedge and wait for its done pulse.
    // A nonzero poke cycle re-asserts start with other operands mid-flight.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int poke);
        int cyc = 0;
        int nb  = 0;
        bit seen = 1'b0;
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        sb_q.push_back(exp);
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (poke != 0 && cyc == poke) begin
                start = 1'b1;
                src_a = ~a;
                src_b = a;
                op    = ~o;
            end
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        check("latency", 64'(cyc), 64'd34);
        check("busy_cycles", 64'(nb), 64'd33);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          nd;

        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; src_a = 32'd0; src_b = 32'd0; wdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", {62'd0, busy, done}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 0);
        @(negedge clk);
        check("done_drop", {63'd0, done}, 64'd0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 0);
        run_op(2'b11, 32'h0000_0007, 32'h0000_0000, {32'h0000_0007, 32'hFFFF_FFFF}, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
            if (i == 5) rb = 32'hFFFF_FFF0;
            run_op(ro, ra, rb, model(ro, ra, rb), 0);
        end

        @(negedge clk);
        wdata = 32'h0000_1234; hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi", {32'd0, hi}, 64'h1234);
        wdata = 32'h0000_5678; lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", {32'd0, lo}, 64'h5678);

        op = 2'b00; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        nd = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            hi_we = (c == 5);
            wdata = 32'hDEAD_BEEF;
            if (done) nd++;
        end
        hi_we = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done) nd++;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_hilo", {hi, lo}, {32'h0000_1234, 32'h0000_5678});
        run_op(2'b01, 32'd3, 32'd4, {32'd0, 32'd12}, 0);
        check("flush_no_done", 64'(nd), 64'd0);

        run_op(2'b01, 32'd10, 32'd20, {32'd0, 32'd200}, 7);

        op = 2'b01; src_a = 32'hFFFF_0000; src_b = 32'h0001_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, model(2'b00, 32'h7FFF_FFFF, 32'h8000_0000), 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS core. It executes MULT, MULTU, DIV and DIVU as a 32-step bit-serial operation and returns the result in HI/LO. It handles MTHI/MTLO writes and exposes `busy` so the hazard logic stalls MFHI/MFLO and any further mul/div issue. It sits beside the ALU in EX and takes its operation code from the instruction decode/ALU control path.

## Interface
- No parameters; data width is fixed at 32.
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: issue request, sampled only in IDLE.
- `op` in 2: operation code.
  - 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU.
- `src_a` in 32: rs operand (multiplicand/dividend).
- `src_b` in 32: rt operand (multiplier/divisor).
- `flush` in 1: abort the in-flight operation (exception/branch flush).
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in 32: MTHI/MTLO write data.
- `busy` out 1: registered; 1 whenever state ≠ IDLE.
- `done` out 1: registered one-cycle pulse on result commit.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- **States:**
  - IDLE → CALC on `start` && !`flush`.
  - CALC → SIGN when the step counter reaches 31.
  - SIGN → IDLE unconditionally.
  - Any state → IDLE on `flush`.
- **Capture (IDLE, start):**
  - Latch `op`.
  - For signed ops, latch |src_a| and |src_b| as 32-bit unsigned; for unsigned ops, latch raw values.
  - Latch sign flags: neg_q = a[31]^b[31] and neg_r = a[31], signed ops only.
  - Clear the 6-bit counter and the 64-bit working register.
- **Multiply, CALC:**
  - Shift-add, LSB first, one multiplier bit per cycle.
  - 64-bit product accumulator, no truncation.
- **Divide, CALC:**
  - Restoring division, one quotient bit per cycle, MSB first.
  - Uses a 33-bit trial subtract; the quotient shifts into the low half and the remainder into the high half.
- **SIGN:**
  - MULT: if neg_q, negate the 64-bit product (two's complement).
  - DIV: if neg_q, negate the quotient; if neg_r, negate the remainder.
  - Commit: multiply writes hi = product[63:32], lo = product[31:0]; divide writes lo = quotient, hi = remainder.
  - Assert `done` for one cycle.
- **Divide by zero** (src_b == 0, captured at start): still runs the full 34-cycle sequence, then commits lo = 32'hFFFFFFFF and hi = raw src_a, with no sign fix.
- **Overflow case:** DIV 0x80000000 / 0xFFFFFFFF commits lo = 0x80000000, hi = 0.
- **MTHI/MTLO:** `hi_we`/`lo_we` write `wdata` at the edge only when in IDLE; they are ignored while `busy`.
- **Start while busy:** ignored; no queueing.
- **`flush`:**
  - Synchronous; takes priority over `start` and over the SIGN commit.
  - HI/LO are unchanged, no `done` pulse, and the next state is IDLE.

## Timing
- **Reset values:**
  - state = IDLE, `busy` = 0, `done` = 0.
  - `hi` = 0, `lo` = 0.
  - Counter and working registers = 0.
- **Sequence:** `start` sampled at edge E0.
  - Edges E1–E32: CALC steps.
  - Edge E33: SIGN commit.
  - `busy` is high from after E0 through E33 (33 cycles).
  - `done` and the new `hi`/`lo` are visible after E33 (34-cycle latency); `done` drops after E34.
- **Back-to-back:** a new `start` is accepted in the cycle `done` is high (state is IDLE), giving 34-cycle throughput.
- **Same-edge events:**
  - `hi_we`/`lo_we` together with `start` in IDLE: the write takes effect at E0; the later commit overwrites it.
  - Operands and `op` are sampled only at E0; later input changes are ignored.
- **Reset during CALC:** immediate return to reset values; no commit.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles `hi` = 0xFFFFFFFE, `lo` = 0x00000001; one `done` pulse; `busy` high for 33 cycles.
- **MULT:** −3 × 5 (0xFFFFFFFD, 0x00000005) → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF1.
- **Signed DIV:**
  - DIV −7 / 2 → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- **Divide by zero:** DIVU 7 / 0 → `lo` = 0xFFFFFFFF, `hi` = 0x00000007 after 34 cycles.
- **Flush and mid-op writes:**
  - MTHI 0x1234 in IDLE → `hi` = 0x1234.
  - Start MULT, assert `hi_we` at cycle 5 → ignored.
  - Assert `flush` at cycle 10 → no `done`, `hi` stays 0x1234, `busy` low after the next edge.
  - An immediate new `start` completes normally.
- **Reset mid-op:** assert `rst` asynchronously mid-CALC → `busy`, `done`, `hi`, `lo` all 0 immediately; `start` while `busy` is ignored (result matches the first operation only).
